id_stage_pipe: RTL

Parametrised decode stage with an integrated ID/EX pipeline register. It decodes an ARM-style 32-bit instruction and reads two operands from an internal register file, with write-back bypass. It evaluates the condition field against the live NZCV flags and registers all control and operand fields toward the EX stage. It sits between IF and EX, and handles hazard stalls, branch flushes and condition-fail bubbles itself.

---
 rtl/id_stage_pipe_pkg.sv | 54 +++++
 rtl/id_regfile.sv | 36 +++
 rtl/id_stage_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg: instruction encodings, condition codes and the ID/EX bundle.
package id_stage_pipe_pkg;
    localparam logic [1:0] MODE_DP = 2'b00, MODE_MEM = 2'b01, MODE_BR = 2'b10;
    localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100,
                           OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010,
                           OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'd0, CMD_MOV = 4'd1, CMD_ADD = 4'd2, CMD_ADC = 4'd3,
                           CMD_SUB = 4'd4, CMD_SBC = 4'd5, CMD_AND = 4'd6, CMD_ORR = 4'd7,
                           CMD_EOR = 4'd8, CMD_MVN = 4'd9;
    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                           COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                           COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                           COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

    // Width-independent part of ID/EX; pc and operands sit beside it in the top.
    typedef struct packed {
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic        wb_en;
        logic        branch;
        logic        s;
        logic [3:0]  exe_cmd;
        logic        imm;
        logic [11:0] shift_op;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } id_ex_t;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/id_regfile.sv
// id_regfile: register file with combinational reads, synchronous write and write-back bypass.
module id_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        addr1,
    input  logic [3:0]        addr2,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam logic [4:0] LIM = 5'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic in1, in2, inw;

    assign in1 = {1'b0, addr1} < LIM;
    assign in2 = {1'b0, addr2} < LIM;
    assign inw = {1'b0, wb_dest} < LIM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        else if (wb_en && inw)
            regs[wb_dest[AW-1:0]] <= wb_data;
    end

    // Unimplemented addresses read 0 even while being written.
    assign rd1 = !in1 ? '0 : (wb_en && wb_dest == addr1) ? wb_data : regs[addr1[AW-1:0]];
    assign rd2 = !in2 ? '0 : (wb_en && wb_dest == addr2) ? wb_data : regs[addr2[AW-1:0]];
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM-style decode, operand read and condition check feeding the ID/EX register.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [31:0]       instr_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hazard,
    input  logic              flush,
    input  logic [3:0]        status,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src,
    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_wb_en,
    output logic              ex_branch,
    output logic              ex_s,
    output logic [3:0]        ex_exe_cmd,
    output logic [DATA_W-1:0] ex_val1,
    output logic [DATA_W-1:0] ex_val2,
    output logic              ex_imm,
    output logic [11:0]       ex_shift_op,
    output logic [23:0]       ex_simm,
    output logic [3:0]        ex_dest,
    output logic [3:0]        ex_src1,
    output logic [3:0]        ex_src2
);
    logic [1:0] mode;
    logic [3:0] op, dp_cmd;
    logic s_bit, store, is_cmp, issue;
    logic [DATA_W-1:0] rd1, rd2, val1_q, val2_q;
    logic [PC_W-1:0] pc_q;
    id_ex_t nx, q;

    assign mode     = instr_in[27:26];
    assign op       = instr_in[24:21];
    assign s_bit    = instr_in[20];
    assign store    = mode == MODE_MEM && !s_bit;
    assign is_cmp   = op == OP_CMP || op == OP_TST;
    assign src1     = instr_in[19:16];
    assign src2     = store ? instr_in[15:12] : instr_in[3:0];
    assign two_src  = in_valid && ((mode == MODE_DP && !instr_in[25]) || store);
    assign in_ready = !hazard;
    assign issue    = !flush && !hazard && in_valid && cond_pass(instr_in[31:28], status);

    id_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
        .clk(clk), .rst(rst), .addr1(src1), .addr2(src2),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .rd1(rd1), .rd2(rd2)
    );

    always_comb begin
        case (op)
            OP_MOV:  dp_cmd = CMD_MOV;
            OP_MVN:  dp_cmd = CMD_MVN;
            OP_ADD:  dp_cmd = CMD_ADD;
            OP_ADC:  dp_cmd = CMD_ADC;
            OP_SUB:  dp_cmd = CMD_SUB;
            OP_SBC:  dp_cmd = CMD_SBC;
            OP_AND:  dp_cmd = CMD_AND;
            OP_ORR:  dp_cmd = CMD_ORR;
            OP_EOR:  dp_cmd = CMD_EOR;
            OP_CMP:  dp_cmd = CMD_SUB;
            OP_TST:  dp_cmd = CMD_AND;
            default: dp_cmd = CMD_NOP;
        endcase
    end

    always_comb begin
        nx          = '0;
        nx.valid    = 1'b1;
        nx.imm      = instr_in[25];
        nx.shift_op = instr_in[11:0];
        nx.simm     = instr_in[23:0];
        nx.dest     = instr_in[15:12];
        nx.src1     = src1;
        nx.src2     = src2;
        case (mode)
            MODE_DP: begin
                nx.exe_cmd = dp_cmd;
                nx.wb_en   = dp_cmd != CMD_NOP && !is_cmp;
                nx.s       = is_cmp || (dp_cmd != CMD_NOP && s_bit);
            end
            MODE_MEM: begin
                nx.exe_cmd   = CMD_ADD;
                nx.mem_read  = s_bit;
                nx.wb_en     = s_bit;
                nx.mem_write = !s_bit;
            end
            MODE_BR: nx.branch = 1'b1;
            default: ;
        endcase
        // Bubble: controls cleared, data fields still travel.
        if (!issue) {nx.valid, nx.mem_read, nx.mem_write, nx.wb_en, nx.branch, nx.s, nx.exe_cmd} = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            pc_q   <= '0;
            val1_q <= '0;
            val2_q <= '0;
        end else begin
            q      <= nx;
            pc_q   <= pc_in;
            val1_q <= rd1;
            val2_q <= rd2;
        end
    end

    assign ex_valid     = q.valid;
    assign ex_mem_read  = q.mem_read;
    assign ex_mem_write = q.mem_write;
    assign ex_wb_en     = q.wb_en;
    assign ex_branch    = q.branch;
    assign ex_s         = q.s;
    assign ex_exe_cmd   = q.exe_cmd;
    assign ex_imm       = q.imm;
    assign ex_shift_op  = q.shift_op;
    assign ex_simm      = q.simm;
    assign ex_dest      = q.dest;
    assign ex_src1      = q.src1;
    assign ex_src2      = q.src2;
    assign ex_pc        = pc_q;
    assign ex_val1      = val1_q;
    assign ex_val2      = val2_q;
endmodule
